// File: rtl/mux_2_pkg.sv
// Shared types and defaults for the 2:1 data selector.
package mux_2_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic [DEFAULT_WIDTH-1:0] mux_data_t;

  localparam mux_data_t DEFAULT_RST_VAL = '0;

endpackage

// File: rtl/mux_2_reg.sv
// Width-parameterised flop with enable and synchronous active-high reset.
module mux_2_reg #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mux_2.sv
// 2:1 data selector with a combinational output and a registered copy
// (data plus select) for consumers that need a flop boundary.
module mux_2
  import mux_2_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_r,
  output logic             s_r
);

  logic [WIDTH-1:0] y_p0;
  logic [WIDTH-1:0] y_p1;
  logic             s_p1;

  // Conditional operator keeps an unknown select from collapsing agreeing bits.
  assign y_p0 = s ? d1 : d0;
  assign y    = y_p0;

  // Stage p0 -> p1: capture selected data and select together
  mux_2_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_data_reg (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (y_p0),
    .q   (y_p1)
  );

  mux_2_reg #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_sel_reg (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (s),
    .q   (s_p1)
  );

  assign y_r = y_p1;
  assign s_r = s_p1;

endmodule

// File: tb/tb_mux_2.sv
// Bench for mux_2: directed steps, exhaustive sweep and randomized cycles
// against a reference that selects from an indexed pair.
module tb_mux_2;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] d0  = '0;
  logic [W-1:0] d1  = '0;
  logic         s   = 1'b0;
  logic [W-1:0] y;
  logic [W-1:0] y_r;
  logic         s_r;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_yr;
  logic         exp_sr;

  mux_2 #(.WIDTH(W), .RST_VAL('0)) dut (
    .clk (clk),
    .rst (rst),
    .d0  (d0),
    .d1  (d1),
    .s   (s),
    .y   (y),
    .y_r (y_r),
    .s_r (s_r)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pick(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic sel);
    logic [W-1:0] pair [2];
    pair[0] = a;
    pair[1] = b;
    return pair[sel];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check y and the held y_r, then check the capture.
  task automatic cycle(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sel, input bit chk_hold);
    @(negedge clk);
    rst = r; d0 = a; d1 = b; s = sel;
    #1;
    chk("y_comb", y, pick(a, b, sel));
    if (chk_hold) begin
      chk("y_r_hold", y_r, exp_yr);
      chk("s_r_hold", W'(s_r), W'(exp_sr));
    end
    @(posedge clk);
    exp_yr = r ? '0 : pick(a, b, sel);
    exp_sr = r ? 1'b0 : sel;
    #1;
    chk("y_r", y_r, exp_yr);
    chk("s_r", W'(s_r), W'(exp_sr));
  endtask

  initial begin
    // Reset for two edges, y follows inputs throughout
    cycle(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0);
    cycle(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1);
    chk("reset_y_r", y_r, 4'b0000);
    chk("reset_y", y, 4'b0001);

    // Select 0
    cycle(1'b0, 4'b0001, 4'b1110, 1'b0, 1'b1);
    chk("sel0_y_r", y_r, 4'b0001);

    // Select 1: y changes immediately, y_r lags one edge
    @(negedge clk);
    s = 1'b1;
    #1;
    chk("sel1_y_now", y, 4'b1110);
    chk("sel1_y_r_old", y_r, 4'b0001);
    @(posedge clk);
    #1;
    chk("sel1_y_r", y_r, 4'b1110);
    chk("sel1_s_r", W'(s_r), W'(1'b1));
    exp_yr = 4'b1110;
    exp_sr = 1'b1;

    // New data, select 0
    cycle(1'b0, 4'b1010, 4'b0101, 1'b0, 1'b1);
    chk("new_y_r", y_r, 4'b1010);

    // Reset mid-stream: registered clears, y keeps tracking
    cycle(1'b1, 4'b1010, 4'b0101, 1'b0, 1'b1);
    chk("mid_rst_y_r", y_r, 4'b0000);
    chk("mid_rst_y", y, 4'b1010);
    cycle(1'b0, 4'b1010, 4'b0101, 1'b0, 1'b1);
    chk("post_rst_y_r", y_r, 4'b1010);

    // Exhaustive sweep of all data pairs and both selects
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 2; k++)
          cycle(1'b0, W'(i), W'(j), k[0], 1'b1);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 300; n++)
      cycle($urandom_range(0, 15) == 0, W'($urandom), W'($urandom), 1'($urandom), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_2.md
Name: mux_2

Overview:
- Parameterised 2:1 data selector; default 4-bit data path.
- Primary output y is purely combinational: d1 when s=1, else d0.
- A registered copy (y_r, s_r) feeds downstream synchronous logic that needs a flop boundary.
- Leaf block for datapath steering inside larger units.

Parameters:
- WIDTH, default 4, data width of d0, d1, y, y_r.
- RST_VAL, default '0 (WIDTH bits), value loaded into y_r on reset.

Ports:
- clk  input  1  system clock; rising edge active.
- rst  input  1  reset, synchronous, active-high.
- d0  input  WIDTH  data input selected when s=0.
- d1  input  WIDTH  data input selected when s=1.
- s  input  1  select.
- y  output  WIDTH  combinational selected data.
- y_r  output  WIDTH  registered selected data, one-cycle latency.
- s_r  output  1  registered select, aligned with y_r.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high: sampled only on the rising edge of clk. No asynchronous reset term anywhere.
- Combinational path:
  - y = s ? d1 : d0, with zero clock latency.
  - y is not affected by clk or rst.
  - y must settle within the same delta/settle window as the inputs change; no latching.
- X handling:
  - s = X or Z: y = d0 when d0 == d1 bitwise, else X on the differing bits.
  - An implementation using the conditional operator satisfies this.
- Registered path, at each rising clk edge:
  - rst=1: y_r <= RST_VAL, s_r <= 0.
  - else: y_r <= (s ? d1 : d0), s_r <= s.
- Latency: y_r and s_r reflect the inputs sampled at the previous edge.
- Reset mid-operation:
  - Registered outputs clear on the edge where rst=1.
  - Capture resumes on the first edge with rst=0.
  - y keeps tracking the inputs throughout reset.
- Simultaneous change: when s and the data inputs change in the same cycle, the register captures the values present at the edge. No priority between inputs.
- Power-up: y_r and s_r are undefined until the first reset edge. Benches must apply rst before checking the registered outputs.
- Width rule: no truncation or extension. All data ports are exactly WIDTH bits.

Decomposition:
- Package mux_2_pkg holds:
  - localparam DEFAULT_WIDTH = 4.
  - typedef logic [DEFAULT_WIDTH-1:0] mux_data_t.
  - Default reset value constant.
- No sub-module needed. Optionally factor the output register into a generic reg_en_rst (width-parameterised flop with synchronous active-high reset) when reused elsewhere.

Test Plan:
- Reset: rst=1 for 2 edges -> y_r=0000, s_r=0. Meanwhile y follows the inputs (d0=0001, s=0 -> y=0001).
- Select 0: d0=0001, d1=1110, s=0, wait 10 ns -> y=0001. After the next edge, y_r=0001, s_r=0.
- Select 1: hold data, s=1, wait 10 ns -> y=1110 immediately. y_r is still 0001 until the next edge, then 1110, s_r=1.
- New data, select 0: d0=1010, d1=0101, s=0 -> y=1010. Next edge y_r=1010.
- Reset mid-stream: y_r=1010, assert rst for one edge -> y_r=0000, s_r=0 while y stays 1010. Deassert -> next edge y_r=1010.
- Exhaustive combinational sweep: all 16x16 d0/d1 pairs for both s values -> y matches s?d1:d0 every time. Registered path matches with one-edge lag.
